// File: rtl/sync_packet_receiver_pkg.sv
// Shared constants, state encoding and BCD helper for the clock-sync link.
package sync_packet_receiver_pkg;

    localparam logic [7:0] SYNC_HEADER_DEFAULT = 8'hA5;
    localparam int unsigned SYNC_PAYLOAD_BYTES = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } rx_state_t;

    // True when both nibbles are decimal digits and the two-digit value lies in [lo, hi].
    function automatic logic bcd_in_range(input logic [7:0] b, input int unsigned lo,
                                          input int unsigned hi);
        int unsigned val;
        val = 32'(b[7:4]) * 10 + 32'(b[3:0]);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/sync_field_check.sv
// Combinational plausibility check of a 56-bit time/date payload.
module sync_field_check
    import sync_packet_receiver_pkg::*;
(
    input  logic [55:0] payload,
    output logic        valid
);

    logic yr_ok, mon_ok, day_ok, hr_ok, min_ok, sec_ok, wk_ok;

    // Month-vs-day consistency is deliberately left to the date counter.
    always_comb begin
        yr_ok  = bcd_in_range(payload[7:0],   0, 99);
        mon_ok = bcd_in_range(payload[15:8],  1, 12);
        day_ok = bcd_in_range(payload[23:16], 1, 31);
        hr_ok  = bcd_in_range(payload[31:24], 0, 23);
        min_ok = bcd_in_range(payload[39:32], 0, 59);
        sec_ok = bcd_in_range(payload[47:40], 0, 59);
        wk_ok  = (payload[51:48] <= 4'd6) && (payload[55:52] == 4'd0);
        valid  = yr_ok && mon_ok && day_ok && hr_ok && min_ok && sec_ok && wk_ok;
    end

endmodule

// File: rtl/sync_packet_receiver.sv
// Parses HDR,P0..P6,CHK frames from the UART byte stream into sync_buffer with a sync strobe.
module sync_packet_receiver
    import sync_packet_receiver_pkg::*;
#(
    parameter logic [7:0]  SYNC_HEADER  = SYNC_HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [51:0] sync_buffer,
    output logic        sync,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned     TIMER_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
    localparam logic [2:0]      LAST_BYTE  = 3'(SYNC_PAYLOAD_BYTES - 1);

    rx_state_t          state;
    logic [2:0]         byte_cnt;
    logic [TIMER_W-1:0] timer;
    logic [55:0]        shadow;
    logic [7:0]         xor_acc;
    logic               fields_ok;

    sync_field_check u_field_check (
        .payload (shadow),
        .valid   (fields_ok)
    );

    // Payload datapath: only meaningful while a frame is open, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            xor_acc <= 8'h00;
        end else if (state == ST_PAYLOAD && rx_valid) begin
            shadow[{byte_cnt, 3'b000} +: 8] <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            byte_cnt    <= 3'd0;
            timer       <= '0;
            sync_buffer <= 52'd0;
            sync        <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC_HEADER) begin
                        state    <= ST_PAYLOAD;
                        byte_cnt <= 3'd0;
                        timer    <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_PAYLOAD, ST_CHECK: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        timer <= '0;
                        if (state == ST_PAYLOAD) begin
                            byte_cnt <= byte_cnt + 3'd1;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= ST_CHECK;
                            end
                        end else begin
                            if (rx_data == xor_acc && fields_ok) begin
                                sync_buffer <= shadow[51:0];
                                sync        <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
